// File: rtl/wgt_fetch_if.sv
// Weight fetch bus: SRAM read port plus the push/ack path to the weight buffer.
// master = wgt_fetch side; slave = SRAM / buffer / PE array side.
interface wgt_fetch_if #(
    parameter int ADDR_W = 10
);
    logic                     mem_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [7:0]        mem_rdata;
    logic signed [7:0]        wgt_input;
    logic                     wgt_read;
    logic                     grp_valid;
    logic                     grp_ack;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_rdata,
        output wgt_input,
        output wgt_read,
        output grp_valid,
        input  grp_ack
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_rdata,
        input  wgt_input,
        input  wgt_read,
        input  grp_valid,
        output grp_ack
    );
endinterface

// File: rtl/wgt_fetch.sv
// Weight fetch sequencer: reads NUM_WGT-word groups from weight SRAM and
// pushes them into the weight shift buffer, then waits for grp_ack.
// Ports: clk, rst_n (async low), stall, start/base_addr/num_groups (job),
// busy/done (status), bus (wgt_fetch_if.master: SRAM read + buffer push).
module wgt_fetch #(
    parameter int NUM_WGT = 4,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_groups,
    output logic              busy,
    output logic              done,
    wgt_fetch_if.master       bus
);
    localparam int CW = $clog2(NUM_WGT + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_ACK,
        FINISH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              enter_fetch;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        grp_left;
    logic [CW-1:0]     issued;
    logic [CW-1:0]     pushed;
    logic              rd_vld;
    logic [1:0]        occ;
    logic signed [7:0] f0;
    logic signed [7:0] f1;
    logic signed [7:0] last;
    logic [2:0]        fill;
    logic              issue;
    logic              pop;
    logic              push;

    // Entries held plus the one read still in flight; a same-cycle pop
    // frees one slot, so the limit rises to 3 when popping.
    assign fill  = {1'b0, occ} + {2'b00, rd_vld};
    assign pop   = (occ != 2'd0) && !stall && (state == FETCH);
    assign push  = rd_vld;
    assign issue = (state == FETCH) && !stall
                 && (issued < CW'(NUM_WGT))
                 && (fill < (pop ? 3'd3 : 3'd2));

    assign bus.mem_en    = issue;
    assign bus.mem_addr  = addr;
    assign bus.wgt_read  = pop;
    assign bus.wgt_input = (occ != 2'd0) ? f0 : last;
    assign bus.grp_valid = (state == WAIT_ACK);
    assign busy          = (state != IDLE);
    assign done          = (state == FINISH);

    always_comb begin
        state_nxt   = state;
        enter_fetch = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (num_groups != 8'd0) begin
                        state_nxt   = FETCH;
                        enter_fetch = 1'b1;
                    end else begin
                        state_nxt = FINISH;
                    end
                end
            end
            FETCH: begin
                if (pop && (pushed == CW'(NUM_WGT - 1)))
                    state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.grp_ack) begin
                    if (grp_left == 8'd1) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt   = FETCH;
                        enter_fetch = 1'b1;
                    end
                end
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            grp_left <= '0;
            issued   <= '0;
            pushed   <= '0;
            rd_vld   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_vld <= issue;
            if ((state == IDLE) && start) begin
                addr     <= base_addr;
                grp_left <= num_groups;
            end else begin
                if (issue)
                    addr <= addr + ADDR_W'(1);
                if ((state == WAIT_ACK) && bus.grp_ack)
                    grp_left <= grp_left - 8'd1;
            end
            if (enter_fetch) begin
                issued <= '0;
                pushed <= '0;
            end else begin
                if (issue)
                    issued <= issued + CW'(1);
                if (pop)
                    pushed <= pushed + CW'(1);
            end
        end
    end

    // Two-entry return FIFO; f0 is the head. last keeps the most recently
    // popped weight so wgt_input holds steady while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= 2'd0;
            f0   <= '0;
            f1   <= '0;
            last <= '0;
        end else begin
            if (pop)
                last <= f0;
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0)
                        f0 <= bus.mem_rdata;
                    else
                        f1 <= bus.mem_rdata;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    f0  <= f1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        f0 <= bus.mem_rdata;
                    end else begin
                        f0 <= f1;
                        f1 <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wgt_fetch.sv
// Directed self-checking bench for wgt_fetch: single group, multi-group,
// stall, address wrap, zero-group job, start-while-busy and mid-job reset.
module tb_wgt_fetch;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       stall = 1'b0;
    logic       start = 1'b0;
    logic [9:0] base_addr = '0;
    logic [7:0] num_groups = '0;
    logic       busy;
    logic       done;

    wgt_fetch_if #(.ADDR_W(10)) bus ();

    wgt_fetch #(.NUM_WGT(4), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .start      (start),
        .base_addr  (base_addr),
        .num_groups (num_groups),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [7:0] mem [0:1023];
    always @(posedge clk)
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];

    // monitor, sampled mid-cycle
    logic [9:0] aq[$];
    logic [7:0] wq[$];
    int         wcyc[$];
    int         bad_ack;
    int         bad_stall;
    int         maxocc;

    always @(negedge clk) begin
        if (bus.mem_en) aq.push_back(bus.mem_addr);
        if (bus.wgt_read) begin
            wq.push_back(bus.wgt_input);
            wcyc.push_back(cyc);
        end
        if (bus.mem_en && bus.grp_valid) bad_ack++;
        if (stall && (bus.mem_en || bus.wgt_read)) bad_stall++;
        if (int'(dut.occ) > maxocc) maxocc = int'(dut.occ);
    end

    int n_chk = 0;
    int n_err = 0;
    int t0 = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        aq.delete();
        wq.delete();
        wcyc.delete();
        bad_ack = 0;
        bad_stall = 0;
        maxocc = 0;
    endtask

    task automatic do_start(input logic [9:0] b, input logic [7:0] n);
        start = 1'b1;
        base_addr = b;
        num_groups = n;
        t0 = cyc;
        nxt();
        start = 1'b0;
    endtask

    task automatic ack();
        bus.grp_ack = 1'b1;
        nxt();
        bus.grp_ack = 1'b0;
    endtask

    task automatic wait_gv(input string tag);
        for (int i = 0; i < 50 && !bus.grp_valid; i++) nxt();
        chk(tag, 32'(bus.grp_valid), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 50 && !done; i++) nxt();
        chk(tag, 32'(done), 32'd1);
        nxt();
    endtask

    logic [7:0] e1 [4];
    logic [7:0] e4 [4];
    logic [9:0] a4 [4];

    initial begin
        e1 = '{8'h03, 8'hFF, 8'h7F, 8'h80};
        e4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        a4 = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h010] = 8'sd3;
        mem[10'h011] = -8'sd1;
        mem[10'h012] = 8'sd127;
        mem[10'h013] = -8'sd128;
        for (int i = 4; i < 12; i++) mem[10'h010 + i] = 8'(i * 11 + 5);
        for (int i = 0; i < 4; i++) mem[a4[i]] = e4[i];
        bus.grp_ack = 1'b0;
        bus.mem_rdata = '0;
        clr();

        // reset
        #2 rst_n = 1'b0;
        repeat (3) nxt();
        chk("rst mem_en", 32'(bus.mem_en), 0);
        chk("rst mem_addr", 32'(bus.mem_addr), 0);
        chk("rst wgt_input", 32'(unsigned'(bus.wgt_input)), 0);
        chk("rst wgt_read", 32'(bus.wgt_read), 0);
        chk("rst grp_valid", 32'(bus.grp_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        rst_n = 1'b1;
        nxt();

        // single group, exact cycle timing
        clr();
        do_start(10'h010, 8'd1);
        chk("t1 c1 mem_en", 32'(bus.mem_en), 1);
        chk("t1 c1 addr", 32'(bus.mem_addr), 32'h010);
        chk("t1 c1 busy", 32'(busy), 1);
        nxt();
        chk("t1 c2 wgt_read", 32'(bus.wgt_read), 0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("t1 wgt_read", 32'(bus.wgt_read), 1);
            chk("t1 wgt_input", 32'(unsigned'(bus.wgt_input)), 32'(e1[i]));
        end
        nxt();
        chk("t1 c7 grp_valid", 32'(bus.grp_valid), 1);
        chk("t1 c7 wgt_read", 32'(bus.wgt_read), 0);
        nxt();
        chk("t1 c8 mem_en", 32'(bus.mem_en), 0);
        nxt();
        ack();
        chk("t1 c10 done", 32'(done), 1);
        chk("t1 c10 grp_valid", 32'(bus.grp_valid), 0);
        nxt();
        chk("t1 c11 done", 32'(done), 0);
        chk("t1 c11 busy", 32'(busy), 0);
        chk("t1 nreads", 32'(aq.size()), 4);

        // three groups, ack 5 cycles after grp_valid
        clr();
        do_start(10'h010, 8'd3);
        for (int g = 0; g < 3; g++) begin
            wait_gv("t2 grp_valid");
            chk("t2 pushes", 32'(wq.size()), 32'(4 * (g + 1)));
            repeat (5) nxt();
            ack();
        end
        wait_done("t2 done");
        chk("t2 nreads", 32'(aq.size()), 12);
        for (int i = 0; i < aq.size() && i < 12; i++)
            chk("t2 addr", 32'(aq[i]), 32'(10'h010 + i));
        for (int i = 0; i < wq.size() && i < 12; i++)
            chk("t2 data", 32'(wq[i]), 32'(unsigned'(mem[10'h010 + i])));
        chk("t2 mem_en in wait", 32'(bad_ack), 0);

        // 3-cycle stall right after the second read
        clr();
        do_start(10'h010, 8'd1);
        nxt();
        nxt();
        stall = 1'b1;
        nxt();
        nxt();
        nxt();
        stall = 1'b0;
        wait_gv("t3 grp_valid");
        chk("t3 gv cycle", 32'(cyc - t0), 10);
        chk("t3 npush", 32'(wq.size()), 4);
        if (wq.size() == 4) begin
            chk("t3 first rd", 32'(wcyc[0] - t0), 6);
            chk("t3 last rd", 32'(wcyc[3] - t0), 9);
            for (int i = 0; i < 4; i++)
                chk("t3 data", 32'(wq[i]), 32'(e1[i]));
        end
        chk("t3 max occ", 32'(maxocc), 2);
        chk("t3 act in stall", 32'(bad_stall), 0);
        ack();
        wait_done("t3 done");

        // address wrap
        clr();
        do_start(10'h3FE, 8'd1);
        wait_gv("t4 grp_valid");
        chk("t4 nreads", 32'(aq.size()), 4);
        for (int i = 0; i < aq.size() && i < 4; i++) begin
            chk("t4 addr", 32'(aq[i]), 32'(a4[i]));
            chk("t4 data", 32'(wq[i]), 32'(e4[i]));
        end
        ack();
        wait_done("t4 done");

        // zero groups
        clr();
        do_start(10'h010, 8'd0);
        chk("t5 c1 done", 32'(done), 1);
        chk("t5 c1 busy", 32'(busy), 1);
        nxt();
        chk("t5 c2 done", 32'(done), 0);
        chk("t5 c2 busy", 32'(busy), 0);
        chk("t5 no reads", 32'(aq.size()), 0);

        // start while busy is ignored
        clr();
        do_start(10'h010, 8'd1);
        nxt();
        start = 1'b1;
        num_groups = 8'd0;
        base_addr = 10'h200;
        nxt();
        start = 1'b0;
        wait_gv("t5b grp_valid");
        chk("t5b gv cycle", 32'(cyc - t0), 7);
        chk("t5b nreads", 32'(aq.size()), 4);
        if (aq.size() == 4) begin
            chk("t5b addr0", 32'(aq[0]), 32'h010);
            chk("t5b addr3", 32'(aq[3]), 32'h013);
        end
        ack();
        wait_done("t5b done");

        // reset mid-job
        clr();
        do_start(10'h010, 8'd1);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("t6 mem_en", 32'(bus.mem_en), 0);
        chk("t6 mem_addr", 32'(bus.mem_addr), 0);
        chk("t6 wgt_read", 32'(bus.wgt_read), 0);
        chk("t6 wgt_input", 32'(unsigned'(bus.wgt_input)), 0);
        chk("t6 grp_valid", 32'(bus.grp_valid), 0);
        chk("t6 busy", 32'(busy), 0);
        chk("t6 done", 32'(done), 0);
        nxt();
        rst_n = 1'b1;
        clr();
        repeat (10) nxt();
        chk("t6 no push", 32'(wq.size()), 0);
        chk("t6 no read", 32'(aq.size()), 0);
        chk("t6 idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/wgt_fetch.md
# wgt_fetch

Weight fetch sequencer that sits directly upstream of the 4-deep weight shift buffer. It reads signed 8-bit weights from the weight SRAM (1-cycle read latency) in groups of NUM_WGT consecutive words. It pushes them one per cycle as wgt_input/wgt_read, then holds grp_valid until the PE array acknowledges consumption of the group. It obeys the same global stall as the buffer and never loses an in-flight SRAM read.

## Interface
- NUM_WGT, 4, weights per group; must equal the downstream buffer depth
- ADDR_W, 10, weight SRAM address width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  global stall; same signal that freezes the downstream buffer
- start  in  1  one-cycle job start; sampled only in IDLE
- base_addr  in  ADDR_W  first SRAM address of the job; sampled with start
- num_groups  in  8  groups to load in this job; sampled with start
- mem_en  out  1  SRAM read enable
- mem_addr  out  ADDR_W  SRAM read address
- mem_rdata  in  8 signed  SRAM data; valid the cycle after mem_en
- wgt_input  out  8 signed  weight to downstream buffer
- wgt_read  out  1  shift strobe to downstream buffer
- grp_valid  out  1  downstream buffer holds a complete group
- grp_ack  in  1  consumer is done with the current group
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at job end

## Operation
- FSM states: IDLE, FETCH, WAIT_ACK, FINISH.
  - IDLE→FETCH on start when num_groups≠0.
  - IDLE→FINISH on start when num_groups=0.
  - FETCH→WAIT_ACK on the cycle the NUM_WGT-th wgt_read of the group fires.
  - WAIT_ACK→FETCH on grp_ack if groups remain.
  - WAIT_ACK→FINISH on grp_ack if this was the last group.
  - FINISH→IDLE unconditionally; done=1 for that single cycle.
- start is ignored outside IDLE.
- Address counter is loaded with base_addr on start and increments by 1 per issued read. It runs continuously across groups (group g uses base+g·NUM_WGT … +NUM_WGT−1) and wraps modulo 2^ADDR_W.
- Per-group counters:
  - issued (0..NUM_WGT): reads sent for the current group.
  - pushed (0..NUM_WGT): wgt_read pulses for the current group.
  - Both clear on entry to FETCH.
- Return path:
  - rd_vld is a register loaded with mem_en.
  - When rd_vld=1, mem_rdata is written into a 2-entry FIFO.
- Issue rule: mem_en = (state==FETCH) & ~stall & (issued<NUM_WGT) & (occ + rd_vld − wgt_read < 2), where occ is FIFO occupancy.
- wgt_read = (occ≠0) & ~stall & (state==FETCH). A FIFO pop occurs exactly when wgt_read=1.
- wgt_input = FIFO head. It holds its last value when the FIFO is empty and is 0 after reset.
- grp_valid = (state==WAIT_ACK). grp_ack outside WAIT_ACK is ignored. grp_ack is honoured even while stall=1.
- FIFO push and pop in the same cycle are legal; occupancy is unchanged.

## Timing
- Reset values: mem_en 0, mem_addr 0, wgt_input 0, wgt_read 0, grp_valid 0, busy 0, done 0; FSM in IDLE; FIFO, rd_vld and counters cleared.
- Job start (start at cycle 0, no stall):
  - Cycle 1: FETCH, mem_en=1, mem_addr=base.
  - Cycle 2: rd_vld=1.
  - Cycles 3..2+NUM_WGT: wgt_read=1 (one weight per cycle).
  - Cycle 3+NUM_WGT: grp_valid=1.
- grp_ack at cycle k: next group's first mem_en at k+1.
- Last group: done at k+1, busy low from k+2.
- Stall:
  - A read issued at cycle t with stall rising at t+1 still lands in the FIFO.
  - No mem_en and no wgt_read while stall=1.
  - After stall falls, wgt_read resumes in the same cycle if occ≠0.
- FIFO never exceeds 2 entries; overflow is impossible by the issue rule. The bench asserts this.
- rst_n low mid-job: immediate return to reset values. In-flight read data is discarded and no wgt_read follows release.

## Test plan
- Single group: base=0x010, num_groups=1, SRAM[0x10..0x13]=3,−1,127,−128, no stall → wgt_read cycles 3–6 with those values in order; grp_valid at cycle 7; grp_ack at 9 → done at 10.
- Three groups, ack delayed 5 cycles each → addresses 0x010–0x01B issued exactly once each; exactly 4 wgt_read per group; no mem_en during WAIT_ACK.
- Stall pulse of 3 cycles starting the cycle after the second mem_en → no data loss, occupancy ≤2, same 4 values in order, group completes 3 cycles late.
- Wrap: ADDR_W=10, base=0x3FE, num_groups=1 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- num_groups=0 → no mem_en, done exactly 1 cycle after start; start while busy has no effect.
- rst_n asserted the cycle after a mem_en → all outputs 0 that cycle; after release no wgt_read until a new start.
